// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl
// Purpose  : Memory-stage sequencer for the SEQ Y86-64 datapath. Decodes the
//            access type from icode, issues a single one-cycle read or write
//            to the registered data memory, and captures valM and the memory
//            error. It reports a one-cycle done pulse and the stage status.
// Ports    : clk, rst_n             - clock / async active-low reset
//            start                  - request pulse (accepted only in IDLE)
//            icode, valE, valA, valP- decode/execute results
//            mem_addr/read/write/wdata - data memory request (registered)
//            mem_rdata, mem_err     - data memory registered response
//            valM, busy, done, stat - results to the SEQ controller
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
  parameter int unsigned    W          = 64,
  parameter logic [W-1:0]   ADDR_LIMIT = W'(8191)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [3:0]   icode,
  input  logic [W-1:0] valE,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valP,
  output logic [W-1:0] mem_addr,
  output logic         mem_read,
  output logic         mem_write,
  output logic [W-1:0] mem_wdata,
  input  logic [W-1:0] mem_rdata,
  input  logic         mem_err,
  output logic [W-1:0] valM,
  output logic         busy,
  output logic         done,
  output logic [1:0]   stat
);

  localparam logic [1:0] c_STAT_AOK = 2'd0;
  localparam logic [1:0] c_STAT_HLT = 2'd1;
  localparam logic [1:0] c_STAT_ADR = 2'd2;
  localparam logic [1:0] c_STAT_INS = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t r_state;
  logic   r_isRead;   // remembers whether the in-flight access is a read

  logic         w_isRead;
  logic         w_isWrite;
  logic [W-1:0] w_addr;
  logic [W-1:0] w_wdata;
  logic [1:0]   w_stat;
  logic         w_inRange;

  // Access decode from the instruction code.
  always_comb begin
    w_isRead  = 1'b0;
    w_isWrite = 1'b0;
    w_addr    = valE;
    w_wdata   = valA;
    w_stat    = c_STAT_AOK;
    case (icode)
      4'h5: w_isRead = 1'b1;                          // mrmovq
      4'h9, 4'hB: begin                               // ret, popq
        w_isRead = 1'b1;
        w_addr   = valA;
      end
      4'h4, 4'hA: w_isWrite = 1'b1;                   // rmmovq, pushq
      4'h8: begin                                     // call
        w_isWrite = 1'b1;
        w_wdata   = valP;
      end
      4'h0: w_stat = c_STAT_HLT;
      4'h1, 4'h2, 4'h3, 4'h6, 4'h7: w_stat = c_STAT_AOK;
      default: w_stat = c_STAT_INS;
    endcase
  end

  assign w_inRange = (w_addr <= ADDR_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_isRead  <= 1'b0;
      mem_addr  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_wdata <= '0;
      valM      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stat      <= c_STAT_AOK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if ((w_isRead || w_isWrite) && w_inRange) begin
              r_state   <= S_ACCESS;
              r_isRead  <= w_isRead;
              mem_read  <= w_isRead;
              mem_write <= w_isWrite;
              mem_addr  <= w_addr;
              mem_wdata <= w_isWrite ? w_wdata : '0;
              busy      <= 1'b1;
            end else begin
              // Non-access or out-of-range access: finish without touching
              // memory. Neither case produces a valid read value.
              r_state <= S_DONE;
              done    <= 1'b1;
              valM    <= '0;
              stat    <= (w_isRead || w_isWrite) ? c_STAT_ADR : w_stat;
            end
          end
        end
        S_ACCESS: begin
          // Enables are a single-cycle strobe; address/data stay put.
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          // Memory response registered on the previous edge is valid now.
          stat    <= mem_err ? c_STAT_ADR : c_STAT_AOK;
          valM    <= (r_isRead && !mem_err) ? mem_rdata : '0;
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_ctrl
// Purpose  : Self-checking bench for mem_stage_ctrl with a registered data
//            memory model and a scoreboard of expected completions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valE, valA, valP;
  logic [63:0] mem_addr, mem_wdata, mem_rdata, valM;
  logic        mem_read, mem_write, mem_err, busy, done;
  logic [1:0]  stat;

  mem_stage_ctrl #(.W(64), .ADDR_LIMIT(64'd8191)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode),
    .valE(valE), .valA(valA), .valP(valP),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .valM(valM), .busy(busy), .done(done), .stat(stat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered data memory model: one access per rising edge.
  logic [63:0] mem [0:8191];
  logic        forceErr;
  always @(posedge clk) begin
    mem_err <= 1'b0;
    if (mem_read || mem_write) mem_err <= forceErr;
    if (mem_write && !forceErr) mem[mem_addr[12:0]] <= mem_wdata;
    if (mem_read) mem_rdata <= mem[mem_addr[12:0]];
  end

  typedef struct {
    logic [1:0]  stat;
    logic [63:0] valM;
    int          lat;
    int          nRd;
    int          nWr;
    logic [63:0] addr;
    logic [63:0] wdata;
  } exp_t;

  exp_t sb[$];
  int   nTot = 0;
  int   nBad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTot++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] s, input logic [63:0] vm, input int lat,
                              input int nr, input int nw, input logic [63:0] a,
                              input logic [63:0] d);
    exp_t x;
    x.stat = s; x.valM = vm; x.lat = lat; x.nRd = nr; x.nWr = nw;
    x.addr = a; x.wdata = d;
    return x;
  endfunction

  // Issue one instruction from a negedge, then observe it cycle by cycle.
  task automatic run(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                     input logic [63:0] p, input exp_t x, input bit poke);
    int cyc, nRd, nWr;
    logic [63:0] seenAddr, seenData;
    bit got;
    exp_t q;
    sb.push_back(x);
    icode = ic; valE = e; valA = a; valP = p; start = 1'b1;
    @(negedge clk);
    cyc = 1; got = 0; nRd = 0; nWr = 0; seenAddr = '0; seenData = '0;
    while (!got && cyc <= 8) begin
      start = poke && (cyc == 1);
      if (poke && cyc == 1) icode = 4'h1;
      if (mem_read && mem_write) chk("both_en", 1, 0);
      if (mem_read || mem_write) seenAddr = mem_addr;
      if (mem_read) nRd++;
      if (mem_write) begin nWr++; seenData = mem_wdata; end
      if (done) got = 1;
      else begin @(negedge clk); cyc++; end
    end
    start = 1'b0;
    q = sb.pop_front();
    if (!got) chk("timeout", 0, 1);
    else begin
      chk("lat", cyc, q.lat);
      chk("stat", stat, q.stat);
      chk("valM", valM, q.valM);
      chk("nRd", nRd, q.nRd);
      chk("nWr", nWr, q.nWr);
      if (q.nRd + q.nWr > 0) chk("addr", seenAddr, q.addr);
      if (q.nWr > 0) chk("wdata", seenData, q.wdata);
      @(negedge clk);
      chk("done_pulse", done, 0);
      chk("stat_hold", stat, q.stat);
      chk("busy_idle", busy, 0);
      if (poke) begin
        repeat (3) begin
          @(negedge clk);
          chk("no_2nd_done", done, 0);
        end
      end
    end
  endtask

  initial begin
    int dn;
    for (int i = 0; i < 8192; i++) mem[i] = 64'h0;
    forceErr = 1'b0; start = 1'b0; icode = 4'h1;
    valE = '0; valA = '0; valP = '0; rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // rmmovq then mrmovq
    run(4'h4, 64'h10, 64'hDEAD, 64'h0, mk(2'd0, 64'h0, 3, 0, 1, 64'h10, 64'hDEAD), 0);
    run(4'h5, 64'h10, 64'h0, 64'h0, mk(2'd0, 64'hDEAD, 3, 1, 0, 64'h10, 64'h0), 0);
    // call then ret (valM cleared by the write, then loaded by the read)
    run(4'h8, 64'h18, 64'h99, 64'h42, mk(2'd0, 64'h0, 3, 0, 1, 64'h18, 64'h42), 0);
    run(4'h9, 64'h77, 64'h18, 64'h0, mk(2'd0, 64'h42, 3, 1, 0, 64'h18, 64'h0), 0);

    // Mid-cycle reset: every output clears immediately.
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valM", valM, 0);
    chk("mrst_addr", mem_addr, 0);
    chk("mrst_wdata", mem_wdata, 0);
    chk("mrst_stat", stat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);

    // Address boundary
    run(4'h4, 64'd8191, 64'h1234, 64'h0, mk(2'd0, 64'h0, 3, 0, 1, 64'd8191, 64'h1234), 0);
    run(4'h5, 64'd8191, 64'h0, 64'h0, mk(2'd0, 64'h1234, 3, 1, 0, 64'd8191, 64'h0), 0);
    run(4'h5, 64'd8192, 64'h0, 64'h0, mk(2'd2, 64'h0, 1, 0, 0, 64'h0, 64'h0), 0);
    run(4'h5, 64'h10, 64'h0, 64'h0, mk(2'd0, 64'hDEAD, 3, 1, 0, 64'h10, 64'h0), 0);
    forceErr = 1'b1;
    run(4'h5, 64'h10, 64'h0, 64'h0, mk(2'd2, 64'h0, 3, 1, 0, 64'h10, 64'h0), 0);
    forceErr = 1'b0;

    // Non-access codes
    run(4'h1, 64'h20, 64'h30, 64'h40, mk(2'd0, 64'h0, 1, 0, 0, 64'h0, 64'h0), 0);
    run(4'h0, 64'h20, 64'h30, 64'h40, mk(2'd1, 64'h0, 1, 0, 0, 64'h0, 64'h0), 0);
    run(4'hC, 64'h20, 64'h30, 64'h40, mk(2'd3, 64'h0, 1, 0, 0, 64'h0, 64'h0), 0);

    // popq, then pushq with a stray start during cycle 1
    run(4'hB, 64'h99, 64'h18, 64'h0, mk(2'd0, 64'h42, 3, 1, 0, 64'h18, 64'h0), 0);
    run(4'hA, 64'h20, 64'h55, 64'h0, mk(2'd0, 64'h0, 3, 0, 1, 64'h20, 64'h55), 1);

    // Reset during ACCESS: enable drops at once, no done afterwards.
    icode = 4'hA; valE = 64'h28; valA = 64'h66; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("acc_wr", mem_write, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("acc_rst_wr", mem_write, 0);
    chk("acc_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("acc_rst_nodone", dn, 0);
    chk("acc_rst_mem", mem[40], 0);

    $display("test done: total=%0d bad=%0d", nTot, nBad);
    $finish;
  end

endmodule
`default_nettype wire
